control_sequencer: RTL and testbench

- Hardwired Moore control unit: the controlling end of the datapath control-strobe interface.
- Generates, cycle by cycle, the PCout/MARin/IncPC/ZLowIn/Read/MDRin/MDRout/IRin/Yin/Zlowout/PCin/op_code/register-select strobes that the datapath consumes.
- Covers instruction fetch plus execution of ALU register instructions (ADD, SUB, AND, OR, NEG, NOT) and HALT.
- Sits beside the datapath: reads IR contents back, waits on memory ready.

---
 rtl/control_sequencer_pkg.sv | 38 +++
 rtl/control_sequencer_if.sv | 37 +++
 rtl/reg_select_decoder.sv | 19 +
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared opcodes, state encoding and IR field positions
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_NEG  = 5'b00011;
    localparam logic [4:0] OP_NOT  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_LO  = 23;
    localparam int RB_LO  = 19;
    localparam int RC_LO  = 15;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_HALTED = 4'd7,
        ST_FAULT  = 4'd8
    } state_t;

    function automatic logic is_binary(input logic [4:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    function automatic logic is_unary(input logic [4:0] op);
        return (op == OP_NEG) || (op == OP_NOT);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control-strobe bus between sequencer (master) and datapath (slave)
interface control_sequencer_if #(
    parameter int NUM_REGS = 16
) ();
    logic                Start;
    logic [31:0]         IR;
    logic                Mem_ready;

    logic                PCout;
    logic                Zlowout;
    logic                MDRout;
    logic                MARin;
    logic                PCin;
    logic                MDRin;
    logic                IRin;
    logic                Yin;
    logic                ZLowIn;
    logic                IncPC;
    logic                Read;
    logic [4:0]          op_code;
    logic [NUM_REGS-1:0] Rin;
    logic [NUM_REGS-1:0] Rout;
    logic                Run;
    logic                Fault;

    modport master (
        input  Start, IR, Mem_ready,
        output PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
               IncPC, Read, op_code, Rin, Rout, Run, Fault
    );

    modport slave (
        output Start, IR, Mem_ready,
        input  PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
               IncPC, Read, op_code, Rin, Rout, Run, Fault
    );
endinterface

// File: rtl/reg_select_decoder.sv
// rtl/reg_select_decoder.sv - register-field to one-hot select with enable
module reg_select_decoder #(
    parameter int SEL_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic                i_en,
    input  logic [SEL_W-1:0]    i_sel,
    output logic [NUM_REGS-1:0] o_onehot
);
    // Selectors beyond NUM_REGS-1 decode to no register at all.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (i_en && (int'(i_sel) == i)) begin
                o_onehot[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore fetch/execute control unit
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int SEL_W      = 4,
    parameter int WAIT_LIMIT = 8
) (
    input  logic                 Clock,
    input  logic                 Clear,
    control_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

    state_t              r_state;
    state_t              w_next;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic [CNT_W-1:0]    w_wait_next;

    logic [4:0]          w_opc;
    logic [SEL_W-1:0]    w_ra;
    logic [SEL_W-1:0]    w_rb;
    logic [SEL_W-1:0]    w_rc;
    logic                w_unused_ir;

    logic                w_rin_en;
    logic                w_rout_en;
    logic [SEL_W-1:0]    w_rout_sel;
    logic [NUM_REGS-1:0] w_rin;
    logic [NUM_REGS-1:0] w_rout;

    assign w_opc       = bus.IR[OPC_HI:OPC_LO];
    assign w_ra        = bus.IR[RA_LO +: SEL_W];
    assign w_rb        = bus.IR[RB_LO +: SEL_W];
    assign w_rc        = bus.IR[RC_LO +: SEL_W];
    assign w_unused_ir = ^bus.IR[RC_LO-1:0];

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_wait_next = '0;
        case (r_state)
            ST_IDLE:   if (bus.Start) w_next = ST_T0;
            ST_T0:     w_next = ST_T1;
            ST_T1: begin
                if (bus.Mem_ready) begin
                    w_next = ST_T2;
                end else if (r_wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                    w_next = ST_FAULT;
                end else begin
                    w_wait_next = r_wait_cnt + 1'b1;
                end
            end
            ST_T2:     w_next = ST_T3;
            ST_T3: begin
                if (is_binary(w_opc))       w_next = ST_T4;
                else if (is_unary(w_opc))   w_next = ST_T5;
                else if (w_opc == OP_HALT)  w_next = ST_HALTED;
                else                        w_next = ST_FAULT;
            end
            ST_T4:     w_next = ST_T5;
            ST_T5:     w_next = bus.Start ? ST_T0 : ST_IDLE;
            ST_HALTED: w_next = ST_HALTED;
            ST_FAULT:  w_next = ST_FAULT;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.PCout   = 1'b0;
        bus.Zlowout = 1'b0;
        bus.MDRout  = 1'b0;
        bus.MARin   = 1'b0;
        bus.PCin    = 1'b0;
        bus.MDRin   = 1'b0;
        bus.IRin    = 1'b0;
        bus.Yin     = 1'b0;
        bus.ZLowIn  = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.op_code = 5'b00000;
        w_rin_en    = 1'b0;
        w_rout_en   = 1'b0;
        w_rout_sel  = w_rb;
        case (r_state)
            ST_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.ZLowIn = 1'b1;
            end
            ST_T1: begin
                // PC reload happens once; the read is held across memory wait cycles.
                bus.Zlowout = 1'b1;
                bus.PCin    = (r_wait_cnt == '0);
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
            end
            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
            end
            ST_T3: begin
                if (is_binary(w_opc)) begin
                    w_rout_en = 1'b1;
                    bus.Yin   = 1'b1;
                end else if (is_unary(w_opc)) begin
                    w_rout_en   = 1'b1;
                    bus.op_code = w_opc;
                    bus.ZLowIn  = 1'b1;
                end
            end
            ST_T4: begin
                w_rout_en   = 1'b1;
                w_rout_sel  = w_rc;
                bus.op_code = w_opc;
                bus.ZLowIn  = 1'b1;
            end
            ST_T5: begin
                bus.Zlowout = 1'b1;
                w_rin_en    = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Run   = (r_state != ST_IDLE) && (r_state != ST_HALTED) && (r_state != ST_FAULT);
    assign bus.Fault = (r_state == ST_FAULT);
    assign bus.Rin   = w_rin;
    assign bus.Rout  = w_rout;

    reg_select_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_rin_dec (
        .i_en     (w_rin_en),
        .i_sel    (w_ra),
        .o_onehot (w_rin)
    );

    reg_select_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_rout_dec (
        .i_en     (w_rout_en),
        .i_sel    (w_rout_sel),
        .o_onehot (w_rout)
    );
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;
    localparam int WAIT_LIMIT = 8;

    localparam logic [10:0] B_PCOUT  = 11'h400;
    localparam logic [10:0] B_MARIN  = 11'h200;
    localparam logic [10:0] B_INCPC  = 11'h100;
    localparam logic [10:0] B_ZIN    = 11'h080;
    localparam logic [10:0] B_ZOUT   = 11'h040;
    localparam logic [10:0] B_PCIN   = 11'h020;
    localparam logic [10:0] B_READ   = 11'h010;
    localparam logic [10:0] B_MDRIN  = 11'h008;
    localparam logic [10:0] B_MDROUT = 11'h004;
    localparam logic [10:0] B_IRIN   = 11'h002;
    localparam logic [10:0] B_YIN    = 11'h001;
    localparam logic [10:0] S_T0     = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [10:0] S_T1     = B_ZOUT | B_READ | B_MDRIN;
    localparam logic [10:0] S_T2     = B_MDROUT | B_IRIN;

    localparam logic [31:0] IR_NEG = 32'h18918000;
    localparam logic [31:0] IR_ADD = 32'h00918000;

    typedef struct packed {
        logic [10:0] strb;
        logic [4:0]  op;
        logic [15:0] rin;
        logic [15:0] rout;
        logic        run;
        logic        fault;
    } obs_t;

    typedef struct {
        obs_t exp;
        logic mr;
        logic st;
    } step_t;

    typedef struct {
        logic        start;
        logic        mr;
        logic [31:0] ir;
        obs_t        exp;
    } vec_t;

    logic Clock = 1'b0;
    logic Clear = 1'b1;
    int   errors = 0;
    int   checks = 0;

    step_t trace[$];
    vec_t  vt[$];
    logic  trace_term;
    obs_t  term_obs;

    control_sequencer_if #(.NUM_REGS(16)) bus ();

    control_sequencer #(.NUM_REGS(16), .SEL_W(4), .WAIT_LIMIT(WAIT_LIMIT)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    function automatic obs_t ob(input logic [10:0] s, input logic [4:0] op, input logic [15:0] rin,
                                input logic [15:0] rout, input logic run, input logic fault);
        obs_t o;
        o.strb = s; o.op = op; o.rin = rin; o.rout = rout; o.run = run; o.fault = fault;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t s;
        s.strb  = {bus.PCout, bus.MARin, bus.IncPC, bus.ZLowIn, bus.Zlowout, bus.PCin,
                   bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin};
        s.op    = bus.op_code;
        s.rin   = bus.Rin;
        s.rout  = bus.Rout;
        s.run   = bus.Run;
        s.fault = bus.Fault;
        return s;
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = sample();
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got strb=%h op=%b rin=%h rout=%h run=%b fault=%b, expected strb=%h op=%b rin=%h rout=%h run=%b fault=%b",
                     name, act.strb, act.op, act.rin, act.rout, act.run, act.fault,
                     exp.strb, exp.op, exp.rin, exp.rout, exp.run, exp.fault);
        end
    endtask

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input obs_t e, input logic mr, input logic st);
        step_t s;
        s.exp = e; s.mr = mr; s.st = st;
        trace.push_back(s);
    endfunction

    // Expected per-cycle observation list for one instruction, starting at its fetch cycle.
    function automatic void build(input logic [31:0] ir, input int wl, input logic next_start);
        logic [4:0]  opc  = ir[31:27];
        logic [15:0] ra_m = 16'h1 << ir[26:23];
        logic [15:0] rb_m = 16'h1 << ir[22:19];
        logic [15:0] rc_m = 16'h1 << ir[18:15];
        bit binary = (opc == 5'd0) || (opc == 5'd1) || (opc == 5'd2) || (opc == 5'd5);
        bit unary  = (opc == 5'd3) || (opc == 5'd4);
        trace.delete();
        trace_term = 1'b0;
        push(ob(S_T0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), rbit(), rbit());
        if (wl >= WAIT_LIMIT) begin
            for (int t = 0; t < WAIT_LIMIT; t++)
                push(ob(S_T1 | ((t == 0) ? B_PCIN : 11'h0), 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), 1'b0, rbit());
            term_obs = ob(11'h0, 5'd0, 16'h0, 16'h0, 1'b0, 1'b1);
            push(term_obs, rbit(), rbit());
            trace_term = 1'b1;
            return;
        end
        for (int t = 0; t <= wl; t++)
            push(ob(S_T1 | ((t == 0) ? B_PCIN : 11'h0), 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), (t == wl), rbit());
        push(ob(S_T2, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), rbit(), rbit());
        if (binary) begin
            push(ob(B_YIN, 5'd0, 16'h0, rb_m, 1'b1, 1'b0), rbit(), rbit());
            push(ob(B_ZIN, opc, 16'h0, rc_m, 1'b1, 1'b0), rbit(), rbit());
        end else if (unary) begin
            push(ob(B_ZIN, opc, 16'h0, rb_m, 1'b1, 1'b0), rbit(), rbit());
        end else begin
            push(ob(11'h0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0), rbit(), rbit());
            term_obs = ob(11'h0, 5'd0, 16'h0, 16'h0, 1'b0, (opc != 5'd27));
            push(term_obs, rbit(), rbit());
            trace_term = 1'b1;
            return;
        end
        push(ob(B_ZOUT, 5'd0, ra_m, 16'h0, 1'b1, 1'b0), rbit(), next_start);
    endfunction

    task automatic run_trace(input string name, input logic chained, input int stop_at);
        if (!chained) begin
            check({name, "_idle"}, '0);
            bus.Start = 1'b1;
            bus.Mem_ready = rbit();
            @(posedge Clock); #1;
        end
        for (int j = 0; j < trace.size(); j++) begin
            check($sformatf("%s_c%0d", name, j), trace[j].exp);
            if (j == stop_at) return;
            bus.Mem_ready = trace[j].mr;
            bus.Start     = trace[j].st;
            @(posedge Clock); #1;
        end
    endtask

    task automatic run_instr(input string name, input logic [31:0] ir, input int wl,
                             input logic next_start, input logic chained);
        bus.IR = ir;
        build(ir, wl, next_start);
        run_trace(name, chained, -1);
    endtask

    task automatic hold_and_clear(input string name);
        for (int k = 0; k < 3; k++) begin
            bus.Start = rbit();
            bus.Mem_ready = rbit();
            @(posedge Clock); #1;
            check({name, "_hold"}, term_obs);
        end
        Clear = 1'b1;
        #1 check({name, "_clear"}, '0);
        @(posedge Clock); #1;
        check({name, "_clear_held"}, '0);
        bus.Start = 1'b0;
        Clear = 1'b0;
    endtask

    function automatic void add_vec(input logic st, input logic mr, input logic [31:0] ir, input obs_t e);
        vec_t v;
        v.start = st; v.mr = mr; v.ir = ir; v.exp = e;
        vt.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic chain;
        logic [4:0] ops [6];
        ops[0] = 5'd0; ops[1] = 5'd1; ops[2] = 5'd2; ops[3] = 5'd3; ops[4] = 5'd4; ops[5] = 5'd5;

        bus.Start = 1'b0;
        bus.IR = 32'h0;
        bus.Mem_ready = 1'b0;
        Clear = 1'b1;
        repeat (2) @(posedge Clock);
        #1 check("reset", '0);
        Clear = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.Mem_ready = rbit();
            @(posedge Clock); #1;
            check("idle_no_start", '0);
        end

        add_vec(1'b1, 1'b1, IR_NEG, ob(S_T0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        add_vec(1'b1, 1'b1, IR_NEG, ob(S_T1 | B_PCIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        add_vec(1'b1, 1'b1, IR_NEG, ob(S_T2, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        add_vec(1'b1, 1'b1, IR_NEG, ob(B_ZIN, 5'b00011, 16'h0, 16'h0004, 1'b1, 1'b0));
        add_vec(1'b0, 1'b1, IR_NEG, ob(B_ZOUT, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0));
        add_vec(1'b0, 1'b1, IR_NEG, '0);
        add_vec(1'b1, 1'b1, IR_ADD, ob(S_T0, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        add_vec(1'b1, 1'b1, IR_ADD, ob(S_T1 | B_PCIN, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        add_vec(1'b1, 1'b1, IR_ADD, ob(S_T2, 5'd0, 16'h0, 16'h0, 1'b1, 1'b0));
        add_vec(1'b1, 1'b1, IR_ADD, ob(B_YIN, 5'd0, 16'h0, 16'h0004, 1'b1, 1'b0));
        add_vec(1'b1, 1'b1, IR_ADD, ob(B_ZIN, 5'b00000, 16'h0, 16'h0008, 1'b1, 1'b0));
        add_vec(1'b0, 1'b1, IR_ADD, ob(B_ZOUT, 5'd0, 16'h0002, 16'h0, 1'b1, 1'b0));
        add_vec(1'b0, 1'b1, IR_ADD, '0);
        for (int i = 0; i < vt.size(); i++) begin
            bus.Start = vt[i].start;
            bus.Mem_ready = vt[i].mr;
            bus.IR = vt[i].ir;
            @(posedge Clock); #1;
            check($sformatf("vec%0d", i), vt[i].exp);
        end

        run_instr("wait3", 32'h08A40000, 3, 1'b0, 1'b0);
        run_instr("timeout", IR_ADD, WAIT_LIMIT, 1'b0, 1'b0);
        hold_and_clear("timeout");
        run_instr("illegal", 32'hF8918000, 0, 1'b0, 1'b0);
        hold_and_clear("illegal");
        run_instr("halt", 32'hD8000000, 0, 1'b0, 1'b0);
        hold_and_clear("halt");
        run_instr("b2b_not", 32'h21100000, 0, 1'b1, 1'b0);
        run_instr("b2b_or", 32'h2F7F8000, 1, 1'b0, 1'b1);
        run_instr("same_reg", 32'h08888000, 0, 1'b0, 1'b0);

        bus.IR = IR_ADD;
        build(IR_ADD, 0, 1'b0);
        run_trace("mid_t4", 1'b0, 4);
        Clear = 1'b1;
        #1 check("clear_mid_t4", '0);
        #2 Clear = 1'b0;
        bus.Start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge Clock); #1;
            check("idle_after_clear", '0);
        end

        chain = 1'b0;
        for (int n = 0; n < 40; n++) begin
            int          r;
            int          x;
            int          wl;
            logic [4:0]  opc;
            logic        nxt;
            r = $urandom_range(0, 19);
            if (r < 18)       opc = ops[r % 6];
            else if (r == 18) opc = 5'd27;
            else              opc = 5'($urandom_range(6, 26));
            x  = $urandom_range(0, 12);
            wl = (x == 12) ? WAIT_LIMIT : (x % 4);
            nxt = rbit();
            run_instr($sformatf("rnd%0d", n), {opc, 27'($urandom)}, wl, nxt, chain);
            if (trace_term) begin
                hold_and_clear($sformatf("rnd%0d", n));
                chain = 1'b0;
            end else begin
                chain = nxt;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
